// File: rtl/core_boot_ctrl.sv
//------------------------------------------------------------------------------
// core_boot_ctrl: loads a program image into dpram with the core held, then
// runs it until halt or timeout. Optional macro BOOT_CHECKSUM_EN adds an XOR
// image checksum that must match before the core is released.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module core_boot_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_WORDS      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  core_run_o,
    input  logic                  halt_i,
    output logic                  done_o,
    output logic [1:0]            status_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] chksum_o,
    input  logic [DATA_WIDTH-1:0] exp_chksum_i
`endif
);

    localparam int                    IDX_WIDTH = $clog2(MEM_WORDS + 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_FULL  = IDX_WIDTH'(MEM_WORDS);
    localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK       = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DRAIN   = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IDX_WIDTH-1:0] idx;
    logic                 accept;
    logic                 restart;
    logic                 chk_bad;

`ifdef BOOT_CHECKSUM_EN
    assign chk_bad = (chksum_o != exp_chksum_i);
`else
    assign chk_bad = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        restart      = 1'b0;
        load_ready_o = 1'b0;
        core_run_o   = 1'b0;
        done_o       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    restart    = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    accept = 1'b1;
                    // A word arriving with the memory already full is an overflow, even if marked last.
                    if (idx == IDX_FULL) begin
                        next_state = S_ERROR;
                    end else if (load_last_i) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                next_state = chk_bad ? S_ERROR : S_RUN;
            end
            S_RUN: begin
                core_run_o = 1'b1;
                if (halt_i) begin
                    next_state = S_DONE;
                end else if (cycle_cnt_o == CNT_LIMIT) begin
                    next_state = S_TIMEOUT;
                end
            end
            S_DONE, S_TIMEOUT, S_ERROR: begin
                done_o = 1'b1;
                if (start_i) begin
                    restart    = 1'b1;
                    next_state = S_LOAD;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx         <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            status_o    <= 2'b00;
            cycle_cnt_o <= '0;
`ifdef BOOT_CHECKSUM_EN
            chksum_o    <= '0;
`endif
        end else begin
            mem_we_o <= 1'b0;
            if (restart) begin
                idx         <= '0;
                status_o    <= 2'b00;
                cycle_cnt_o <= '0;
`ifdef BOOT_CHECKSUM_EN
                chksum_o    <= '0;
`endif
            end
            if (accept) begin
                if (idx == IDX_FULL) begin
                    status_o <= ST_OVERFLOW;
                end else begin
                    mem_we_o   <= 1'b1;
                    mem_addr_o <= BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
                    mem_data_o <= load_data_i;
                    idx        <= idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    chksum_o   <= chksum_o ^ load_data_i;
`endif
                end
            end
            // Preloading 1 here makes the count read 1 during the first RUN cycle.
            if (state == S_DRAIN) begin
                if (chk_bad) begin
                    status_o <= ST_OVERFLOW;
                end else begin
                    cycle_cnt_o <= CNT_WIDTH'(1);
                end
            end
            if (state == S_RUN) begin
                if (halt_i) begin
                    status_o <= ST_OK;
                end else if (cycle_cnt_o == CNT_LIMIT) begin
                    status_o <= ST_TIMEOUT;
                end else if (cycle_cnt_o != '1) begin
                    cycle_cnt_o <= cycle_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_boot_ctrl.sv
//------------------------------------------------------------------------------
// tb_core_boot_ctrl: directed and randomized boot scenarios for core_boot_ctrl,
// judged against an outcome model of writes, status and cycle count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_boot_ctrl;

    localparam int              AW   = 32;
    localparam int              DW   = 32;
    localparam int              MW   = 4;
    localparam int              TO   = 50;
    localparam int              CW   = 32;
    localparam logic [AW-1:0]   BASE = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          lvalid = 1'b0;
    logic [DW-1:0] ldata = '0;
    logic          llast = 1'b0;
    logic          halt = 1'b0;
    logic          lready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          core_run;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycle_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0] chksum;
    logic [DW-1:0] exp_chksum = '0;
`endif

    core_boot_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW),
        .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .load_valid_i(lvalid), .load_data_i(ldata), .load_last_i(llast),
        .load_ready_o(lready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .core_run_o(core_run), .halt_i(halt),
        .done_o(done), .status_o(status), .cycle_cnt_o(cycle_cnt)
`ifdef BOOT_CHECKSUM_EN
        , .chksum_o(chksum), .exp_chksum_i(exp_chksum)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            ncyc = 0;
    int            run_cnt = 0;

    always @(negedge clk) begin
        ncyc++;
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(ncyc);
        end
        if (core_run) run_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last, input bit gap, output bit ok);
        int guard;
        if (gap) begin
            lvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        lvalid = 1'b1;
        ldata  = d;
        llast  = last;
        halt   = ($urandom_range(0, 1) == 1);
        guard  = 0;
        while (!lready && guard < 8) begin
            tick();
            guard++;
        end
        ok = lready;
        if (ok) tick();
        lvalid = 1'b0;
        llast  = 1'b0;
        halt   = 1'b0;
    endtask

    // Outcome model: writes are the first min(n, MW) words at BASE+4*i; more than
    // MW words (or a bad checksum) ends in status 3 with the core never run;
    // otherwise halt on run cycle h<=TO gives status 1 / count h, else status 2 / count TO.
    task automatic do_boot(input logic [DW-1:0] words[$], input int halt_at, input bit gaps,
                           input bit ck_force, input logic [DW-1:0] ck_val);
        int            n, wbase, rbase, nexp, k, rc, noise_at, exp_cnt;
        logic [1:0]    exp_st;
        logic [DW-1:0] x;
        bit            ovf, ckerr, ok;
        n      = words.size();
        wbase  = wr_addr_q.size();
        rbase  = run_cnt;
        x      = '0;
        foreach (words[i]) x ^= words[i];
        ovf    = (n > MW);
        ckerr  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        exp_chksum = ck_force ? ck_val : x;
        ckerr      = !ovf && (exp_chksum != x);
`else
        if (ck_force && ck_val != x) ckerr = 1'b0;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_status", 64'(status), 64'(0));
        check_eq("start_count", 64'(cycle_cnt), 64'(0));
        for (int i = 0; i < n; i++) begin
            send_word(words[i], i == n - 1, gaps, ok);
            if (!ok) begin
                check_eq("load_ready_wait", 64'(0), 64'(1));
                return;
            end
        end
`ifdef BOOT_CHECKSUM_EN
        if (!ovf) check_eq("chksum", 64'(chksum), 64'(x));
`endif
        if (ovf || ckerr) begin
            repeat (2) tick();
            check_eq("err_status", 64'(status), 64'(3));
            check_eq("err_done", 64'(done), 64'(1));
            check_eq("err_never_run", 64'(run_cnt - rbase), 64'(0));
            nexp = ovf ? MW : n;
        end else begin
            nexp = n;
            k = 1;
            while (!core_run && k < 6) begin
                tick();
                k++;
            end
            check_eq("run_rise_cycles", 64'(k), 64'(2));
            check_eq("run_first_count", 64'(cycle_cnt), 64'(1));
            exp_st   = (halt_at >= 1 && halt_at <= TO) ? 2'd1 : 2'd2;
            exp_cnt  = (exp_st == 2'd1) ? halt_at : TO;
            noise_at = $urandom_range(2, 10);
            rc = 1;
            while (!done && rc < TO + 20) begin
                halt  = (rc == halt_at);
                start = (rc == noise_at);
                tick();
                halt  = 1'b0;
                start = 1'b0;
                rc++;
            end
            check_eq("run_status", 64'(status), 64'(exp_st));
            check_eq("run_count", 64'(cycle_cnt), 64'(exp_cnt));
            check_eq("run_done", 64'(done), 64'(1));
            check_eq("run_core_released", 64'(core_run), 64'(0));
        end
        check_eq("write_count", 64'(wr_addr_q.size() - wbase), 64'(nexp));
        for (int i = 0; i < nexp && wbase + i < wr_addr_q.size(); i++) begin
            check_eq("write_addr", 64'(wr_addr_q[wbase + i]), 64'(BASE + AW'(4 * i)));
            check_eq("write_data", 64'(wr_data_q[wbase + i]), 64'(words[i]));
            if (!gaps && i > 0)
                check_eq("write_b2b", 64'(wr_cyc_q[wbase + i] - wr_cyc_q[wbase + i - 1]), 64'(1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 64'(lready), 64'(0));
        check_eq({tag, "_we"}, 64'(mem_we), 64'(0));
        check_eq({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check_eq({tag, "_data"}, 64'(mem_data), 64'(0));
        check_eq({tag, "_run"}, 64'(core_run), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(0));
        check_eq({tag, "_status"}, 64'(status), 64'(0));
        check_eq({tag, "_count"}, 64'(cycle_cnt), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[$];
        int            wb, n, h;
        bit            ok;

        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;
        tick();

        // Valid words in IDLE are not accepted and cause no write.
        wb = wr_addr_q.size();
        lvalid = 1'b1;
        ldata  = 32'hDEADBEEF;
        repeat (2) tick();
        check_eq("idle_ready", 64'(lready), 64'(0));
        lvalid = 1'b0;
        tick();
        check_eq("idle_no_write", 64'(wr_addr_q.size() - wb), 64'(0));

        w = '{32'h00000013, 32'h00100093, 32'hFFFFFFFF};
        do_boot(w, 25, 1'b0, 1'b0, '0);

        w = '{$urandom(), $urandom()};
        do_boot(w, 0, 1'b0, 1'b0, '0);
        do_boot(w, 50, 1'b0, 1'b0, '0);

        w = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        do_boot(w, 10, 1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of a load.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hAAAA0001, 1'b0, 1'b0, ok);
        send_word(32'hAAAA0002, 1'b0, 1'b0, ok);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        w = '{32'h12345678};
        do_boot(w, 5, 1'b0, 1'b0, '0);

`ifdef BOOT_CHECKSUM_EN
        w = '{32'hA5A5A5A5, 32'h0F0F0F0F};
        do_boot(w, 3, 1'b0, 1'b1, 32'hAAAAAAAA);
        do_boot(w, 3, 1'b0, 1'b1, 32'h00000000);
`endif

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, MW + 1);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom());
            h = $urandom_range(0, 60);
            do_boot(w, h, ($urandom_range(0, 1) == 1), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
